// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data_sram responder: word memory, byte-lane writes, one-cycle reads
//
// Optional build macro: DSRAM_PERF_CNT_EN (adds rd_cnt / wr_cnt access counters)
//
// Ports:
//   clk                  clock, all state updates on the rising edge
//   resetn               synchronous active-low reset
//   data_sram_en         access request this cycle
//   data_sram_we[3:0]    byte write enables (bit i -> wdata[8i+7:8i]); 0 means read
//   data_sram_addr[31:0] byte address (bits [1:0] ignored)
//   data_sram_wdata      write data
//   data_sram_rdata      registered read data, holds until the next read
//   data_sram_rvalid     one-cycle pulse after a read request
//   err_oob              sticky out-of-range flag
//   err_addr             address of the first out-of-range access since reset
//   rd_cnt, wr_cnt       saturating access counters (DSRAM_PERF_CNT_EN only)

module data_sram_resp #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        err_oob,
    output logic [31:0] err_addr
`ifdef DSRAM_PERF_CNT_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] index;
    logic                  in_range;
    logic                  is_write;
    logic                  rd_fire;
    logic                  wr_fire;

    logic [31:0] rdata_q;
    logic        rvalid_q, rvalid_d;
    logic        err_oob_q, err_oob_d;
    logic [31:0] err_addr_q, err_addr_d;

    // Byte offset is ignored: every access is word-aligned.
    logic unused_byte_offset;
    assign unused_byte_offset = ^data_sram_addr[1:0];

    assign index = data_sram_addr[ADDR_WIDTH+1:2];

    // At ADDR_WIDTH=30 the word index spans the whole address, so nothing is out of range.
    generate
        if (ADDR_WIDTH >= 30) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = (data_sram_addr[31:ADDR_WIDTH+2] == '0);
        end
    endgenerate

    assign is_write = (data_sram_we != 4'b0000);
    assign rd_fire  = data_sram_en && !is_write;
    assign wr_fire  = data_sram_en &&  is_write;

    // Array is never cleared; reset only suppresses a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (resetn && wr_fire && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Out-of-range reads return zero but still pulse rvalid.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= 32'h0;
        end else if (rd_fire) begin
            rdata_q <= in_range ? mem[index] : 32'h0;
        end
    end

    always_comb begin
        rvalid_d   = rd_fire;
        err_oob_d  = err_oob_q;
        err_addr_d = err_addr_q;
        if (data_sram_en && !in_range) begin
            err_oob_d = 1'b1;
            // Keep only the first offender.
            if (!err_oob_q) begin
                err_addr_d = data_sram_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rvalid_q   <= 1'b0;
            err_oob_q  <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            rvalid_q   <= rvalid_d;
            err_oob_q  <= err_oob_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign data_sram_rdata  = rdata_q;
    assign data_sram_rvalid = rvalid_q;
    assign err_oob          = err_oob_q;
    assign err_addr         = err_addr_q;

`ifdef DSRAM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Counters include out-of-range accesses and stick at all-ones.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_fire && (rd_cnt_q != 32'hFFFF_FFFF)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (wr_fire && (wr_cnt_q != 32'hFFFF_FFFF)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_cnt_q <= 32'h0;
            wr_cnt_q <= 32'h0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - directed self-checking bench for data_sram_resp

module tb_data_sram_resp;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err_oob;
    logic [31:0] err_addr;
`ifdef DSRAM_PERF_CNT_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
`endif

    int n_cmp;
    int n_fail;

    data_sram_resp #(.ADDR_WIDTH(16)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .data_sram_en     (en),
        .data_sram_we     (we),
        .data_sram_addr   (addr),
        .data_sram_wdata  (wdata),
        .data_sram_rdata  (rdata),
        .data_sram_rvalid (rvalid),
        .err_oob          (err_oob),
        .err_addr         (err_addr)
`ifdef DSRAM_PERF_CNT_EN
        ,
        .rd_cnt           (rd_cnt),
        .wr_cnt           (wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given request, then return to idle; outputs settle #1 after the edge.
    task automatic cycle(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en    = e;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        en    = 1'b0;
        we    = 4'h0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        cycle(1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b0, 4'h0, 32'h0, 32'h0);
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        n_cmp++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL reset_err_oob got=%b exp=0", err_oob); end
        n_cmp++; if (err_addr !== 32'h0) begin n_fail++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
        resetn = 1'b1;
    endtask

    task automatic test_full_write_read;
        cycle(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL write_rvalid got=%b exp=0", rvalid); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL write_rdata_held got=%h exp=0", rdata); end
        cycle(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL full_read_rdata got=%h exp=deadbeef", rdata); end
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL full_read_rvalid got=%b exp=1", rvalid); end
        cycle(1'b0, 4'h0, 32'h0, 32'h0);
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid got=%b exp=0", rvalid); end
        n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL idle_rdata_hold got=%h exp=deadbeef", rdata); end
    endtask

    task automatic test_byte_lanes;
        cycle(1'b1, 4'b0101, 32'h0000_0010, 32'h1122_3344);
        cycle(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        n_cmp++; if (rdata !== 32'hDE22_BE44) begin n_fail++; $display("FAIL lane_read got=%h exp=de22be44", rdata); end
        cycle(1'b1, 4'b1000, 32'h0000_0013, 32'h7700_0000);
        cycle(1'b1, 4'h0, 32'h0000_0013, 32'h0);
        n_cmp++; if (rdata !== 32'h7722_BE44) begin n_fail++; $display("FAIL lane_unaligned got=%h exp=7722be44", rdata); end
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL lane_rvalid got=%b exp=1", rvalid); end
    endtask

    task automatic test_out_of_range;
        cycle(1'b1, 4'hF, 32'h0000_0000, 32'hA5A5_0001);
        // 0x4_0000 would alias word 0 if the high bits were dropped instead of rejected.
        cycle(1'b1, 4'hF, 32'h0004_0000, 32'hFFFF_FFFF);
        n_cmp++; if (err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_flag got=%b exp=1", err_oob); end
        n_cmp++; if (err_addr !== 32'h0004_0000) begin n_fail++; $display("FAIL oob_addr got=%h exp=00040000", err_addr); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL oob_write_rvalid got=%b exp=0", rvalid); end
        cycle(1'b1, 4'h0, 32'h0008_0004, 32'h0);
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL oob_read_rdata got=%h exp=0", rdata); end
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL oob_read_rvalid got=%b exp=1", rvalid); end
        n_cmp++; if (err_addr !== 32'h0004_0000) begin n_fail++; $display("FAIL oob_first_kept got=%h exp=00040000", err_addr); end
        cycle(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        n_cmp++; if (rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL oob_no_alias got=%h exp=a5a50001", rdata); end
        n_cmp++; if (err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_sticky got=%b exp=1", err_oob); end
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 4'hF, 32'h0000_0020, 32'h1234_5678);
        resetn = 1'b0;
        cycle(1'b1, 4'hF, 32'h0000_0020, 32'hCAFE_F00D);
        resetn = 1'b1;
        n_cmp++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL midrst_err_oob got=%b exp=0", err_oob); end
        n_cmp++; if (err_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_err_addr got=%h exp=0", err_addr); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata got=%h exp=0", rdata); end
        cycle(1'b1, 4'h0, 32'h0000_0020, 32'h0);
        n_cmp++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL midrst_retained got=%h exp=12345678", rdata); end
    endtask

    task automatic test_back_to_back;
        cycle(1'b1, 4'hF, 32'h0000_0030, 32'h0BAD_F00D);
        cycle(1'b1, 4'h0, 32'h0000_0030, 32'h0);
        n_cmp++; if (rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_wr_rd got=%h exp=0badf00d", rdata); end
        cycle(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        n_cmp++; if (rdata !== 32'h7722_BE44) begin n_fail++; $display("FAIL b2b_rd2 got=%h exp=7722be44", rdata); end
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid got=%b exp=1", rvalid); end
        cycle(1'b1, 4'hF, 32'h0003_FFFC, 32'h5555_AAAA);
        cycle(1'b1, 4'h0, 32'h0003_FFFC, 32'h0);
        n_cmp++; if (rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL top_word got=%h exp=5555aaaa", rdata); end
        n_cmp++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL top_word_in_range got=%b exp=0", err_oob); end
    endtask

`ifdef DSRAM_PERF_CNT_EN
    task automatic test_perf_cnt;
        resetn = 1'b0;
        cycle(1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        cycle(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        cycle(1'b1, 4'hF, 32'h0000_0040, 32'h1);
        cycle(1'b1, 4'h0, 32'h0008_0000, 32'h0);
        cycle(1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 4'h2, 32'h0000_0044, 32'h2);
        cycle(1'b1, 4'h0, 32'h0000_0040, 32'h0);
        n_cmp++; if (rd_cnt !== 32'd3) begin n_fail++; $display("FAIL rd_cnt got=%0d exp=3", rd_cnt); end
        n_cmp++; if (wr_cnt !== 32'd2) begin n_fail++; $display("FAIL wr_cnt got=%0d exp=2", wr_cnt); end
        dut.rd_cnt_q = 32'hFFFF_FFFF;
        cycle(1'b1, 4'h0, 32'h0000_0040, 32'h0);
        n_cmp++; if (rd_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rd_cnt_sat got=%h exp=ffffffff", rd_cnt); end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        resetn = 1'b0;
        en     = 1'b0;
        we     = 4'h0;
        addr   = 32'h0;
        wdata  = 32'h0;
        test_reset;
        test_full_write_read;
        test_byte_lanes;
        test_out_of_range;
        test_reset_mid;
        test_back_to_back;
`ifdef DSRAM_PERF_CNT_EN
        test_perf_cnt;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
